cordic_engine: RTL and testbench

- Pipelined, parametrised CORDIC engine with a valid/ready handshake on ingress and egress.
- Supports two modes, selectable per transaction:
  - rotation: sine/cosine of an angle, or rotation of an input vector;
  - vectoring: magnitude and atan2 of a vector.
- Full-circle angle input and output.
- A pass-through tag identifies each transaction.
- Sits between NCO/DSP producers and consumers that may apply backpressure.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_stage.sv | 66 ++++++
 rtl/cordic_engine.sv | 144 ++++++++++++++
 tb/tb_cordic_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants: atan table, angle constants, mode enum.
package cordic_pkg;

  typedef enum logic {
    ROTATION  = 1'b0,
    VECTORING = 1'b1
  } cordic_mode_t;

  localparam logic [31:0] PI_HALF       = 32'h4000_0000;
  localparam logic [31:0] MINUS_PI_HALF = 32'hC000_0000;

  // atan(2^-i) scaled so that 2^32 is a full circle
  localparam logic [31:0] ATAN_TABLE [31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one registered CORDIC micro-rotation with pipeline enable.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int          W_P     = 18,
  parameter int          TAG_W_P = 8,
  parameter int          STAGE_P = 0,
  parameter logic [31:0] ATAN_P  = 32'h2000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  prev_valid,
  input  logic                  prev_mode,
  input  logic [TAG_W_P-1:0]    prev_tag,
  input  logic signed [W_P-1:0] prev_x,
  input  logic signed [W_P-1:0] prev_y,
  input  logic [31:0]           prev_z,
  output logic                  valid,
  output logic                  mode,
  output logic [TAG_W_P-1:0]    tag,
  output logic signed [W_P-1:0] x,
  output logic signed [W_P-1:0] y,
  output logic [31:0]           z
);

  logic signed [W_P-1:0] x_sh;
  logic signed [W_P-1:0] y_sh;
  logic                  d_pos;
  logic                  hold;

  assign x_sh  = prev_x >>> STAGE_P;
  assign y_sh  = prev_y >>> STAGE_P;
  assign d_pos = (prev_mode == VECTORING) ? prev_y[W_P-1] : !prev_z[31];
  // a zero vector has no angle; freezing it keeps z at 0 instead of summing the table
  assign hold  = (prev_mode == VECTORING) && (prev_x == '0) && (prev_y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      tag   <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
    end else if (en) begin
      valid <= prev_valid;
      mode  <= prev_mode;
      tag   <= prev_tag;
      if (hold) begin
        x <= prev_x;
        y <= prev_y;
        z <= prev_z;
      end else if (d_pos) begin
        x <= prev_x - y_sh;
        y <= prev_y + x_sh;
        z <= prev_z - ATAN_P;
      end else begin
        x <= prev_x + y_sh;
        y <= prev_y - x_sh;
        z <= prev_z + ATAN_P;
      end
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - pipelined rotation/vectoring CORDIC with valid/ready stream ends.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH_P   = 16,
  parameter int NR_OF_STAGES_P = 16,
  parameter int TAG_WIDTH_P    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ing_valid,
  output logic                    ing_ready,
  input  logic                    ing_mode,
  input  logic [TAG_WIDTH_P-1:0]  ing_tag,
  input  logic [DATA_WIDTH_P-1:0] ing_x,
  input  logic [DATA_WIDTH_P-1:0] ing_y,
  input  logic [31:0]             ing_z,
  output logic                    egr_valid,
  input  logic                    egr_ready,
  output logic                    egr_mode,
  output logic [TAG_WIDTH_P-1:0]  egr_tag,
  output logic [DATA_WIDTH_P+1:0] egr_x,
  output logic [DATA_WIDTH_P+1:0] egr_y,
  output logic [31:0]             egr_z
);

  localparam int W = DATA_WIDTH_P + 2;
  localparam int N = NR_OF_STAGES_P;

  logic                   en;
  logic signed [W-1:0]    x_ext, y_ext, pre_x, pre_y;
  logic [31:0]            pre_z;

  logic                   p_valid, p_mode;
  logic [TAG_WIDTH_P-1:0] p_tag;
  logic signed [W-1:0]    p_x, p_y;
  logic [31:0]            p_z;

  logic                   s_valid [0:N];
  logic                   s_mode  [0:N];
  logic [TAG_WIDTH_P-1:0] s_tag   [0:N];
  logic signed [W-1:0]    s_x     [0:N];
  logic signed [W-1:0]    s_y     [0:N];
  logic [31:0]            s_z     [0:N];

  // one enable for the whole pipe: a stall freezes every stage, bubbles included
  assign en        = !egr_valid || egr_ready;
  assign ing_ready = en;

  assign x_ext = {{2{ing_x[DATA_WIDTH_P-1]}}, ing_x};
  assign y_ext = {{2{ing_y[DATA_WIDTH_P-1]}}, ing_y};

  always_comb begin
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = ing_z;
    if (ing_mode == ROTATION) begin
      case (ing_z[31:30])
        2'b01: begin
          pre_x = -y_ext;
          pre_y = x_ext;
          pre_z = {2'b00, ing_z[29:0]};
        end
        2'b10: begin
          pre_x = y_ext;
          pre_y = -x_ext;
          pre_z = {2'b11, ing_z[29:0]};
        end
        default: ;
      endcase
    end else begin
      pre_z = '0;
      if (x_ext[W-1]) begin
        if (!y_ext[W-1]) begin
          pre_x = y_ext;
          pre_y = -x_ext;
          pre_z = PI_HALF;
        end else begin
          pre_x = -y_ext;
          pre_y = x_ext;
          pre_z = MINUS_PI_HALF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_mode  <= 1'b0;
      p_tag   <= '0;
      p_x     <= '0;
      p_y     <= '0;
      p_z     <= '0;
    end else if (en) begin
      p_valid <= ing_valid;
      p_mode  <= ing_mode;
      p_tag   <= ing_tag;
      p_x     <= pre_x;
      p_y     <= pre_y;
      p_z     <= pre_z;
    end
  end

  assign s_valid[0] = p_valid;
  assign s_mode[0]  = p_mode;
  assign s_tag[0]   = p_tag;
  assign s_x[0]     = p_x;
  assign s_y[0]     = p_y;
  assign s_z[0]     = p_z;

  for (genvar i = 0; i < N; i++) begin : g_stage
    cordic_stage #(
      .W_P    (W),
      .TAG_W_P(TAG_WIDTH_P),
      .STAGE_P(i),
      .ATAN_P (ATAN_TABLE[i])
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .prev_valid(s_valid[i]),
      .prev_mode (s_mode[i]),
      .prev_tag  (s_tag[i]),
      .prev_x    (s_x[i]),
      .prev_y    (s_y[i]),
      .prev_z    (s_z[i]),
      .valid     (s_valid[i+1]),
      .mode      (s_mode[i+1]),
      .tag       (s_tag[i+1]),
      .x         (s_x[i+1]),
      .y         (s_y[i+1]),
      .z         (s_z[i+1])
    );
  end

  assign egr_valid = s_valid[N];
  assign egr_mode  = s_mode[N];
  assign egr_tag   = s_tag[N];
  assign egr_x     = s_x[N];
  assign egr_y     = s_y[N];
  assign egr_z     = s_z[N];

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - scoreboard bench for cordic_engine with directed vectors.
module tb_cordic_engine;

  localparam int DW = 16;
  localparam int NS = 16;
  localparam int TW = 8;
  localparam int OW = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ing_valid = 1'b0;
  logic          ing_ready;
  logic          ing_mode = 1'b0;
  logic [TW-1:0] ing_tag = '0;
  logic [DW-1:0] ing_x = '0;
  logic [DW-1:0] ing_y = '0;
  logic [31:0]   ing_z = '0;
  logic          egr_valid;
  logic          egr_ready = 1'b1;
  logic          egr_mode;
  logic [TW-1:0] egr_tag;
  logic [OW-1:0] egr_x, egr_y;
  logic [31:0]   egr_z;

  always #5 clk = ~clk;

  cordic_engine #(.DATA_WIDTH_P(DW), .NR_OF_STAGES_P(NS), .TAG_WIDTH_P(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ing_valid(ing_valid), .ing_ready(ing_ready), .ing_mode(ing_mode), .ing_tag(ing_tag),
    .ing_x(ing_x), .ing_y(ing_y), .ing_z(ing_z),
    .egr_valid(egr_valid), .egr_ready(egr_ready), .egr_mode(egr_mode), .egr_tag(egr_tag),
    .egr_x(egr_x), .egr_y(egr_y), .egr_z(egr_z)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic          mode;
    int            ex, ey, tx, ty;
    logic [31:0]   ez;
    int            tz;
    bit            lat;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int zdiff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return int'($signed(d));
  endfunction

  // monitor: also owns egr_ready so that stall bookkeeping sees the value the next edge uses
  bit            stall = 1'b0;
  int            low_cnt = 0;
  logic [TW-1:0] s_tag;
  logic          s_mode;
  logic [OW-1:0] s_x, s_y;
  logic [31:0]   s_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      chk("ing_ready", ing_ready == (!egr_valid || egr_ready), ing_ready, !egr_valid || egr_ready);
      if (stall)
        chk("stall_stable", egr_valid && egr_tag == s_tag && egr_mode == s_mode &&
            egr_x == s_x && egr_y == s_y && egr_z == s_z, egr_x, s_x);
      if (bp) begin
        if (low_cnt > 0) begin
          egr_ready = 1'b0;
          low_cnt--;
        end else begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) begin
            low_cnt   = 4;
            egr_ready = 1'b0;
          end else begin
            egr_ready = (r > 3);
          end
        end
      end else begin
        egr_ready = 1'b1;
      end
      stall = 1'b0;
      if (egr_valid && egr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1'b0, egr_tag, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tag", egr_tag == e.tag, egr_tag, e.tag);
          chk("mode", egr_mode == e.mode, egr_mode, e.mode);
          chk("x", iabs(int'($signed(egr_x)) - e.ex) <= e.tx, int'($signed(egr_x)), e.ex);
          chk("y", iabs(int'($signed(egr_y)) - e.ey) <= e.ty, int'($signed(egr_y)), e.ey);
          chk("z", iabs(zdiff(egr_z, e.ez)) <= e.tz, egr_z, e.ez);
          if (e.lat) chk("latency", cyc == e.cyc, cyc, e.cyc);
        end
      end else if (egr_valid) begin
        stall  = 1'b1;
        s_tag  = egr_tag;
        s_mode = egr_mode;
        s_x    = egr_x;
        s_y    = egr_y;
        s_z    = egr_z;
      end
    end
  end

  // called at negedge+1; holds ing_valid until the transfer edge is known
  task automatic send(input bit mode, input int x, input int y, input logic [31:0] z,
                      input logic [TW-1:0] tag, input int ex, input int ey, input int tx,
                      input int ty, input logic [31:0] ez, input int tz, input bit lat);
    int   guard;
    exp_t e;
    guard     = 0;
    ing_valid = 1'b1;
    ing_mode  = mode;
    ing_tag   = tag;
    ing_x     = DW'(x);
    ing_y     = DW'(y);
    ing_z     = z;
    while (!ing_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("ing_accept", ing_ready, ing_ready, 1);
    e.tag = tag; e.mode = mode; e.ex = ex; e.ey = ey; e.tx = tx; e.ty = ty;
    e.ez = ez; e.tz = tz; e.lat = lat; e.cyc = cyc + NS + 1;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic send_vec(input int k, input logic [TW-1:0] tag, input bit lat);
    case (k)
      0: send(0, 19898, 0, 32'h2000_0000, tag, 23170, 23170, 4, 4, 32'h0, 1 << 17, lat);
      1: send(0, 19898, 0, 32'h6000_0000, tag, -23170, 23170, 4, 4, 32'h0, 1 << 17, lat);
      2: send(0, 19898, 0, 32'hA000_0000, tag, -23170, -23170, 4, 4, 32'h0, 1 << 17, lat);
      3: send(1, 3000, 4000, 32'h0, tag, 8234, 0, 4, 8, 32'd633866811, 1 << 18, lat);
      4: send(1, -10000, 0, 32'h0, tag, 16468, 0, 4, 8, 32'h8000_0000, 1 << 18, lat);
      5: send(0, -32768, -32768, 32'h1000_0000, tag, -29204, -70504, 16, 16, 32'h0, 1 << 17, lat);
      6: send(1, -32768, -32768, 32'h0, tag, 76312, 0, 8, 8, 32'hA000_0000, 1 << 18, lat);
      default: send(1, 0, 0, 32'h1234_5678, tag, 0, 0, 0, 0, 32'h0, 0, lat);
    endcase
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("drain", sb.size() == 0, sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", egr_valid == 1'b0, egr_valid, 0);
    chk("reset_data", egr_x == '0 && egr_y == '0 && egr_z == '0 && egr_tag == '0, egr_z, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_reset", ing_ready == 1'b1, ing_ready, 1);

    for (int k = 0; k < 8; k++) begin
      send_vec(k, TW'(k), 1'b1);
      if (k % 2 == 1) begin
        ing_valid = 1'b0;
        repeat (k) begin
          @(negedge clk);
          #1;
        end
      end
    end
    ing_valid = 1'b0;
    drain();

    bp = 1'b1;
    for (int t = 0; t < 40; t++) send_vec(t % 8, TW'(t), 1'b0);
    ing_valid = 1'b0;
    drain();
    bp = 1'b0;
    @(negedge clk);
    #1;

    for (int t = 0; t < 10; t++) send_vec(t % 8, TW'(100 + t), 1'b0);
    ing_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", egr_valid == 1'b0, egr_valid, 0);
    chk("async_reset_data", egr_x == '0 && egr_y == '0 && egr_z == '0 && egr_tag == '0,
        egr_x, 0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    chk("no_stale", egr_valid == 1'b0, egr_valid, 0);
    send_vec(0, TW'(200), 1'b1);
    ing_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
